// File: rtl/counter_pkg.sv
// Shared types for the counter bank: channel modes, reset mode and a helper for
// sizing the channel-select field.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam mode_e MODE_RESET = MODE_UP;

  // A single-channel bank still needs a one-bit select so out-of-range writes exist.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: holds count, bounce direction and mode; steps when told to
// and produces a wrap pulse registered alongside the count.
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             mode_we_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  mode_e            mode_q;
  logic             dir_down_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;

  logic             eff_down;
  logic [WIDTH-1:0] bounce_next;

  // A count parked on an end (e.g. after a load) turns around instead of overflowing.
  always_comb begin
    eff_down    = dir_down_q ? (count_q != ZERO) : (count_q == MAX);
    bounce_next = eff_down ? (count_q - ONE) : (count_q + ONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q     <= MODE_RESET;
      dir_down_q <= 1'b0;
      count_q    <= ZERO;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (mode_we_i) begin
        mode_q <= mode_i;
        if (ld_i) begin
          count_q    <= ld_val_i;
          dir_down_q <= 1'b0;
        end
      end else if (step_i) begin
        case (mode_q)
          MODE_UP: begin
            count_q <= count_q + ONE;
            wrap_q  <= (count_q == MAX);
          end
          MODE_DOWN: begin
            count_q <= count_q - ONE;
            wrap_q  <= (count_q == ZERO);
          end
          MODE_BOUNCE: begin
            count_q <= bounce_next;
            if (bounce_next == MAX) begin
              dir_down_q <= 1'b1;
              wrap_q     <= 1'b1;
            end else if (bounce_next == ZERO) begin
              dir_down_q <= 1'b0;
              wrap_q     <= 1'b1;
            end else begin
              dir_down_q <= eff_down;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent counters sharing one tick prescaler; drives the
// output pad bus with the packed counts and per-channel wrap pulses.
module counter_bank
  import counter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         en_i,
  input  logic [PRESC_W-1:0]        presc_div_i,
  input  logic                      cfg_we_i,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch_i,
  input  mode_e                     cfg_mode_i,
  input  logic                      cfg_load_i,
  input  logic [WIDTH-1:0]          cfg_val_i,
  output logic [NUM_CH*WIDTH-1:0]   count_o,
  output logic [NUM_CH-1:0]         wrap_o
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [PRESC_W-1:0] presc_cnt_q;
  logic               tick;
  logic [NUM_CH-1:0]  cfg_hit;
  logic [NUM_CH-1:0]  step;

  // >= rather than == so lowering the divider below the running count ticks at once.
  assign tick = (presc_cnt_q >= presc_div_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q <= '0;
    end else if (tick) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign cfg_hit[c] = cfg_we_i && (cfg_ch_i == CH_W'(c));
    assign step[c]    = tick && en_i[c] && !cfg_hit[c];

    counter_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .step_i   (step[c]),
      .ld_i     (cfg_load_i),
      .ld_val_i (cfg_val_i),
      .mode_we_i(cfg_hit[c]),
      .mode_i   (cfg_mode_i),
      .count_o  (count_o[c*WIDTH +: WIDTH]),
      .wrap_o   (wrap_o[c])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: a 3x8-bit bank and a 1x1-bit bank driven
// together, checked against a behavioural model of the counting rules.
module tb_counter_bank;
  import counter_pkg::*;

  typedef struct packed {
    logic [23:0] cnt;
    logic [2:0]  wrp;
    logic        cntb;
    logic        wrpb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [2:0]  en_a;
  logic [0:0]  en_b;
  logic [7:0]  presc_div;
  logic        cfg_we;
  logic [1:0]  cfg_ch_a;
  logic [0:0]  cfg_ch_b;
  mode_e       cfg_mode;
  logic        cfg_load;
  logic [7:0]  cfg_val_a;
  logic [0:0]  cfg_val_b;
  logic [23:0] count_a;
  logic [2:0]  wrap_a;
  logic [0:0]  count_b;
  logic [0:0]  wrap_b;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  int m_cnt[4];
  int m_dir[4];
  int m_mode[4];
  bit m_wrap[4];
  int m_presc_a;
  int m_presc_b;

  always #5 clk = ~clk;

  counter_bank #(.NUM_CH(3), .WIDTH(8), .PRESC_W(8)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_a), .presc_div_i(presc_div),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch_a), .cfg_mode_i(cfg_mode),
    .cfg_load_i(cfg_load), .cfg_val_i(cfg_val_a),
    .count_o(count_a), .wrap_o(wrap_a)
  );

  counter_bank #(.NUM_CH(1), .WIDTH(1), .PRESC_W(8)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_b), .presc_div_i(presc_div),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch_b), .cfg_mode_i(cfg_mode),
    .cfg_load_i(cfg_load), .cfg_val_i(cfg_val_b),
    .count_o(count_b), .wrap_o(wrap_b)
  );

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void modelReset();
    m_presc_a = 0;
    m_presc_b = 0;
    for (int c = 0; c < 4; c++) begin
      m_cnt[c]  = 0;
      m_dir[c]  = 1;
      m_mode[c] = 0;
      m_wrap[c] = 1'b0;
    end
  endfunction

  // Counting rules: modular up/down, bounce reverses at either end, hold freezes.
  function automatic void modelChannel(input int c, input int maxv, input bit stp,
                                       input bit hit, input bit load, input int val,
                                       input int mode);
    m_wrap[c] = 1'b0;
    if (hit) begin
      m_mode[c] = mode;
      if (load) begin
        m_cnt[c] = val;
        m_dir[c] = 1;
      end
    end else if (stp) begin
      case (m_mode[c])
        0: begin
          m_cnt[c]  = (m_cnt[c] + 1) % (maxv + 1);
          m_wrap[c] = (m_cnt[c] == 0);
        end
        1: begin
          m_cnt[c]  = (m_cnt[c] + maxv) % (maxv + 1);
          m_wrap[c] = (m_cnt[c] == maxv);
        end
        2: begin
          if (m_cnt[c] + m_dir[c] < 0 || m_cnt[c] + m_dir[c] > maxv) m_dir[c] = -m_dir[c];
          m_cnt[c] = m_cnt[c] + m_dir[c];
          if (m_cnt[c] == maxv) begin
            m_wrap[c] = 1'b1;
            m_dir[c]  = -1;
          end else if (m_cnt[c] == 0) begin
            m_wrap[c] = 1'b1;
            m_dir[c]  = 1;
          end
        end
        default: begin
        end
      endcase
    end
  endfunction

  // Called at a falling edge: drives inputs, predicts the state after the next
  // rising edge, queues it, then waits for the following falling edge.
  task automatic applyStimulus(input logic [2:0] en, input int div, input bit we,
                               input int ch, input int chb, input int mode,
                               input bit load, input int val);
    exp_t e;
    bit tick_a, tick_b;
    en_a      = en;
    en_b      = en[0];
    presc_div = div[7:0];
    cfg_we    = we;
    cfg_ch_a  = ch[1:0];
    cfg_ch_b  = chb[0];
    cfg_mode  = mode_e'(mode[1:0]);
    cfg_load  = load;
    cfg_val_a = val[7:0];
    cfg_val_b = val[0];

    tick_a    = (m_presc_a >= div);
    m_presc_a = tick_a ? 0 : m_presc_a + 1;
    for (int c = 0; c < 3; c++)
      modelChannel(c, 255, tick_a && en[c], we && (ch == c), load, val % 256, mode);
    tick_b    = (m_presc_b >= div);
    m_presc_b = tick_b ? 0 : m_presc_b + 1;
    modelChannel(3, 1, tick_b && en[0], we && (chb == 0), load, val % 2, mode);

    for (int c = 0; c < 3; c++) begin
      e.cnt[c*8 +: 8] = m_cnt[c][7:0];
      e.wrp[c]        = m_wrap[c];
    end
    e.cntb = m_cnt[3][0];
    e.wrpb = m_wrap[3];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every rising edge presents a new registered output to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int c = 0; c < 3; c++) begin
          checkOutput($sformatf("ch%0d_count", c), count_a[c*8 +: 8], e.cnt[c*8 +: 8]);
          checkOutput($sformatf("ch%0d_wrap", c), wrap_a[c], e.wrp[c]);
        end
        checkOutput("w1_count", count_b, e.cntb);
        checkOutput("w1_wrap", wrap_b, e.wrpb);
      end
    end
  end

  initial begin
    rst_ni    = 1'b0;
    en_a      = 3'b111;
    en_b      = 1'b1;
    presc_div = 8'd0;
    cfg_we    = 1'b0;
    cfg_ch_a  = 2'd0;
    cfg_ch_b  = 1'b0;
    cfg_mode  = MODE_UP;
    cfg_load  = 1'b0;
    cfg_val_a = 8'd0;
    cfg_val_b = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_count_a", count_a, 0);
    checkOutput("reset_wrap_a", wrap_a, 0);
    checkOutput("reset_count_b", count_b, 0);
    checkOutput("reset_wrap_b", wrap_b, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Free-running up-count through a full wrap.
    for (int i = 0; i < 260; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);

    // Divide by 4, then drop the divider while the prescaler sits at 2.
    for (int i = 0; i < 20; i++) applyStimulus(3'b111, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && m_presc_a != 2; i++) applyStimulus(3'b111, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);

    // Channel 1 down from 2, channel 0 keeps counting up.
    applyStimulus(3'b111, 0, 1, 1, 1, 1, 1, 2);
    for (int i = 0; i < 8; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);

    // Channel 2 and the 1-bit bank bounce from 254/0.
    applyStimulus(3'b111, 0, 1, 2, 0, 2, 1, 254);
    for (int i = 0; i < 520; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);

    // Load on a tick cycle wins over the step; out-of-range select is ignored.
    applyStimulus(3'b111, 0, 1, 0, 1, 0, 1, 10);
    applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(3'b111, 0, 1, 3, 1, 3, 1, 99);
    for (int i = 0; i < 4; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 3),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 255));
    end

    // Bounce heading down, then asynchronous reset mid-count.
    applyStimulus(3'b111, 0, 1, 2, 0, 2, 1, 254);
    for (int i = 0; i < 4; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    checkOutput("async_count_a", count_a, 0);
    checkOutput("async_wrap_a", wrap_a, 0);
    checkOutput("async_count_b", count_b, 0);
    checkOutput("async_wrap_b", wrap_b, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    modelReset();
    for (int i = 0; i < 12; i++) applyStimulus(3'b111, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    checkOutput("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
